muldiv_unit: RTL and testbench

- Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
- Sits directly downstream of the register file and consumes its rsdata/rtdata operand outputs for MULT, MULTU, DIV and DIVU.
- Holds the 64-bit result in HI/LO for later MFHI/MFLO reads.
- Accepts MTHI/MTLO writes and provides a start/busy/done handshake so the control path stalls HI/LO consumers.

---
 rtl/muldiv_if.sv | 25 ++
 rtl/muldiv_unit.sv | 127 ++++++++++++
 tb/tb_muldiv_unit.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// Operand, MTHI/MTLO and result bundle between the control path and the multiply/divide unit.
interface muldiv_if #(parameter int WIDTH = 32);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] rsdata;
    logic [WIDTH-1:0] rtdata;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, rsdata, rtdata, hi_we, lo_we, wdata,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, rsdata, rtdata, hi_we, lo_we, wdata,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider owning the HI/LO registers.
// state  | meaning
// IDLE   | accept start or MTHI/MTLO writes
// RUN    | one multiply/divide iteration per cycle on operand magnitudes
// FINISH | apply signs, write HI/LO, pulse done
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic               dz;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic               busy_r;
    logic               done_r;
    logic               dz_r;

    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_final;
    logic [WIDTH-1:0]   quo_final;
    logic [WIDTH-1:0]   rem_final;

    assign a_neg = ~bus.op[0] & bus.rsdata[WIDTH-1];
    assign b_neg = ~bus.op[0] & bus.rtdata[WIDTH-1];
    assign a_abs = a_neg ? -bus.rsdata : bus.rsdata;
    assign b_abs = b_neg ? -bus.rtdata : bus.rtdata;

    // Multiply: low half of acc holds the multiplier, consumed LSB first.
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

    // Divide: upper half is the partial remainder, low half shifts dividend out and quotient in.
    assign div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
    assign div_next  = div_trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                        : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    assign prod_final = neg_q ? -acc : acc;
    assign quo_final  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem_final  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
            opnd   <= '0;
            acc    <= '0;
            hi_r   <= '0;
            lo_r   <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            dz_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            dz_r   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        is_div <= bus.op[1];
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        dz     <= bus.op[1] && (bus.rtdata == '0);
                        opnd   <= bus.op[1] ? b_abs : a_abs;
                        acc    <= {{WIDTH{1'b0}}, (bus.op[1] ? a_abs : b_abs)};
                        cnt    <= CW'(WIDTH - 1);
                        busy_r <= 1'b1;
                        state  <= S_RUN;
                    end else begin
                        if (bus.hi_we) hi_r <= bus.wdata;
                        if (bus.lo_we) lo_r <= bus.wdata;
                    end
                end
                S_RUN: begin
                    acc <= is_div ? div_next : mul_next;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) state <= S_FINISH;
                end
                S_FINISH: begin
                    if (!dz) begin
                        if (is_div) begin
                            hi_r <= rem_final;
                            lo_r <= quo_final;
                        end else begin
                            hi_r <= prod_final[2*WIDTH-1:WIDTH];
                            lo_r <= prod_final[WIDTH-1:0];
                        end
                    end
                    done_r <= 1'b1;
                    dz_r   <= dz;
                    busy_r <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.div_by_zero = dz_r;
    assign bus.hi          = hi_r;
    assign bus.lo          = lo_r;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: latency, result mapping, MTHI/MTLO, busy-time drops and async reset.
module tb_muldiv_unit;
    logic clk;
    logic rst;
    int   passed;
    int   total;

    muldiv_if #(.WIDTH(32)) bus ();

    muldiv_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Entered #1 after a rising edge; start is sampled at the next edge (E0).
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit inject, output int lat, output int bcnt,
                          output bit dz_seen, output bit hi_moved, output bit busy_at_done);
        logic [31:0] h0;
        h0 = bus.hi;
        lat = 0; bcnt = 0; dz_seen = 1'b0; hi_moved = 1'b0; busy_at_done = 1'b0;
        bus.start = 1'b1; bus.op = op; bus.rsdata = a; bus.rtdata = b;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        bus.rsdata = 32'h0BAD_F00D; bus.rtdata = 32'h0000_0000;
        if (bus.busy) bcnt++;
        for (int n = 1; n <= 40; n++) begin
            if (inject && n == 5) begin
                bus.start = 1'b1; bus.op = 2'b01; bus.rsdata = 32'd9; bus.rtdata = 32'd9;
                bus.hi_we = 1'b1; bus.wdata = 32'hDEAD_BEEF;
            end
            if (inject && n == 6) begin
                bus.start = 1'b0; bus.hi_we = 1'b0;
            end
            @(posedge clk); #1;
            if (bus.done) begin
                lat = n;
                dz_seen = bus.div_by_zero;
                busy_at_done = bus.busy;
                break;
            end
            if (bus.busy) bcnt++;
            if (bus.hi !== h0) hi_moved = 1'b1;
        end
    endtask

    task automatic test_reset();
        total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", bus.busy); else passed++;
        total++; if (bus.done !== 1'b0) $display("FAIL reset_done got %0b want 0", bus.done); else passed++;
        total++; if (bus.div_by_zero !== 1'b0) $display("FAIL reset_dz got %0b want 0", bus.div_by_zero); else passed++;
        total++; if (bus.hi !== 32'h0) $display("FAIL reset_hi got %h want 0", bus.hi); else passed++;
        total++; if (bus.lo !== 32'h0) $display("FAIL reset_lo got %h want 0", bus.lo); else passed++;
    endtask

    task automatic test_mult_signed();
        int lat, bcnt; bit dzs, hm, bd;
        run_op(2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0, lat, bcnt, dzs, hm, bd);
        total++; if (lat !== 33) $display("FAIL mult_latency got %0d want 33", lat); else passed++;
        total++; if (bcnt !== 33) $display("FAIL mult_busy_cycles got %0d want 33", bcnt); else passed++;
        total++; if (bd !== 1'b0) $display("FAIL mult_busy_at_done got %0b want 0", bd); else passed++;
        total++; if (hm !== 1'b0) $display("FAIL mult_hi_stable got moved=%0b want 0", hm); else passed++;
        total++; if (bus.hi !== 32'hFFFF_FFFF) $display("FAIL mult_hi got %h want ffffffff", bus.hi); else passed++;
        total++; if (bus.lo !== 32'hFFFF_FFFA) $display("FAIL mult_lo got %h want fffffffa", bus.lo); else passed++;
        @(posedge clk); #1;
        total++; if (bus.done !== 1'b0) $display("FAIL mult_done_pulse got %0b want 0", bus.done); else passed++;
    endtask

    task automatic test_multu_vs_mult();
        int lat, bcnt; bit dzs, hm, bd;
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat, bcnt, dzs, hm, bd);
        total++; if (bus.hi !== 32'hFFFF_FFFE) $display("FAIL multu_hi got %h want fffffffe", bus.hi); else passed++;
        total++; if (bus.lo !== 32'h0000_0001) $display("FAIL multu_lo got %h want 00000001", bus.lo); else passed++;
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat, bcnt, dzs, hm, bd);
        total++; if (bus.hi !== 32'h0000_0000) $display("FAIL mult_m1_hi got %h want 00000000", bus.hi); else passed++;
        total++; if (bus.lo !== 32'h0000_0001) $display("FAIL mult_m1_lo got %h want 00000001", bus.lo); else passed++;
    endtask

    task automatic test_divide();
        int lat, bcnt; bit dzs, hm, bd;
        run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, lat, bcnt, dzs, hm, bd);
        total++; if (bus.lo !== 32'hFFFF_FFFD) $display("FAIL div_neg_lo got %h want fffffffd", bus.lo); else passed++;
        total++; if (bus.hi !== 32'hFFFF_FFFF) $display("FAIL div_neg_hi got %h want ffffffff", bus.hi); else passed++;
        total++; if (dzs !== 1'b0) $display("FAIL div_neg_dz got %0b want 0", dzs); else passed++;
        run_op(2'b11, 32'd7, 32'd2, 1'b0, lat, bcnt, dzs, hm, bd);
        total++; if (bus.lo !== 32'd3) $display("FAIL divu_lo got %h want 00000003", bus.lo); else passed++;
        total++; if (bus.hi !== 32'd1) $display("FAIL divu_hi got %h want 00000001", bus.hi); else passed++;
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat, bcnt, dzs, hm, bd);
        total++; if (bus.lo !== 32'h8000_0000) $display("FAIL div_ovf_lo got %h want 80000000", bus.lo); else passed++;
        total++; if (bus.hi !== 32'h0) $display("FAIL div_ovf_hi got %h want 00000000", bus.hi); else passed++;
        total++; if (lat !== 33) $display("FAIL div_ovf_latency got %0d want 33", lat); else passed++;
    endtask

    task automatic test_mthi_div_by_zero();
        int lat, bcnt; bit dzs, hm, bd;
        bus.hi_we = 1'b1; bus.wdata = 32'h0000_1234;
        @(posedge clk); #1;
        bus.hi_we = 1'b0;
        total++; if (bus.hi !== 32'h0000_1234) $display("FAIL mthi_hi got %h want 00001234", bus.hi); else passed++;
        total++; if (bus.lo !== 32'h8000_0000) $display("FAIL mthi_lo_kept got %h want 80000000", bus.lo); else passed++;
        // hi_we raised alongside start must lose to start.
        bus.hi_we = 1'b1; bus.wdata = 32'h0000_AAAA;
        run_op(2'b11, 32'd5, 32'd0, 1'b0, lat, bcnt, dzs, hm, bd);
        total++; if (lat !== 33) $display("FAIL dz_latency got %0d want 33", lat); else passed++;
        total++; if (dzs !== 1'b1) $display("FAIL dz_flag got %0b want 1", dzs); else passed++;
        total++; if (bus.hi !== 32'h0000_1234) $display("FAIL dz_hi got %h want 00001234", bus.hi); else passed++;
        total++; if (bus.lo !== 32'h8000_0000) $display("FAIL dz_lo got %h want 80000000", bus.lo); else passed++;
        @(posedge clk); #1;
        total++; if (bus.div_by_zero !== 1'b0) $display("FAIL dz_pulse got %0b want 0", bus.div_by_zero); else passed++;
        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'h0000_5678;
        @(posedge clk); #1;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        total++; if (bus.hi !== 32'h0000_5678 || bus.lo !== 32'h0000_5678)
            $display("FAIL mthi_mtlo_both got hi=%h lo=%h want 00005678", bus.hi, bus.lo); else passed++;
    endtask

    task automatic test_ignore_while_busy();
        int lat, bcnt; bit dzs, hm, bd;
        int extra;
        run_op(2'b11, 32'd100, 32'd7, 1'b1, lat, bcnt, dzs, hm, bd);
        total++; if (lat !== 33) $display("FAIL busy_ign_latency got %0d want 33", lat); else passed++;
        total++; if (bus.lo !== 32'd14) $display("FAIL busy_ign_lo got %h want 0000000e", bus.lo); else passed++;
        total++; if (bus.hi !== 32'd2) $display("FAIL busy_ign_hi got %h want 00000002", bus.hi); else passed++;
        total++; if (hm !== 1'b0) $display("FAIL busy_ign_hi_stable got moved=%0b want 0", hm); else passed++;
        extra = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) extra++;
        end
        total++; if (extra !== 0) $display("FAIL busy_ign_no_relaunch got %0d active cycles want 0", extra); else passed++;
    endtask

    task automatic test_back_to_back();
        int lat, bcnt; bit dzs, hm, bd;
        run_op(2'b11, 32'd7, 32'd2, 1'b0, lat, bcnt, dzs, hm, bd);
        run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0004, 1'b0, lat, bcnt, dzs, hm, bd);
        total++; if (lat !== 33) $display("FAIL b2b_latency got %0d want 33", lat); else passed++;
        total++; if (bus.hi !== 32'hFFFF_FFFF) $display("FAIL b2b_hi got %h want ffffffff", bus.hi); else passed++;
        total++; if (bus.lo !== 32'hFFFF_FFF4) $display("FAIL b2b_lo got %h want fffffff4", bus.lo); else passed++;
    endtask

    task automatic test_async_reset();
        int lat, bcnt; bit dzs, hm, bd;
        int dones;
        bus.start = 1'b1; bus.op = 2'b01; bus.rsdata = 32'd3; bus.rtdata = 32'd5;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        total++; if (bus.busy !== 1'b0) $display("FAIL arst_busy got %0b want 0", bus.busy); else passed++;
        total++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0)
            $display("FAIL arst_hilo got hi=%h lo=%h want 0", bus.hi, bus.lo); else passed++;
        @(posedge clk); #1;
        rst = 1'b0;
        dones = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (bus.done) dones++;
        end
        total++; if (dones !== 0) $display("FAIL arst_no_done got %0d pulses want 0", dones); else passed++;
        run_op(2'b01, 32'd3, 32'd5, 1'b0, lat, bcnt, dzs, hm, bd);
        total++; if (lat !== 33) $display("FAIL arst_restart_latency got %0d want 33", lat); else passed++;
        total++; if (bus.lo !== 32'd15 || bus.hi !== 32'd0)
            $display("FAIL arst_restart_result got hi=%h lo=%h want 0/0000000f", bus.hi, bus.lo); else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst = 1'b1;
        bus.start = 1'b0; bus.op = 2'b00; bus.rsdata = '0; bus.rtdata = '0;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_mult_signed();
        test_multu_vs_mult();
        test_divide();
        test_mthi_div_by_zero();
        test_ignore_while_busy();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
